// File: rtl/gearbox_rx_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | gearbox_rx_sync : IN_W -> IN_W*RATIO receive gearbox with bit-slip   |
// |                   sync-header lock state machine                      |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module gearbox_rx_sync #(
  parameter int IN_W      = 20,
  parameter int RATIO     = 4,
  parameter int LOCK_CNT  = 64,
  parameter int WINDOW    = 1024,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 4
) (
  input  logic                          user_clk,
  input  logic                          reset_n,
  input  logic [IN_W-1:0]               data_in,
  output logic [IN_W*RATIO-1:0]         data_out,
  output logic                          data_valid,
  output logic                          locked,
  output logic [$clog2(IN_W*RATIO)-1:0] bit_offset
);

  localparam int OUT_W  = IN_W * RATIO;
  localparam int BUF_W  = 2 * OUT_W;
  localparam int HIST_W = BUF_W - IN_W;
  localparam int OFF_W  = $clog2(OUT_W);
  localparam int WC_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int GC_W   = $clog2(LOCK_CNT + 1);
  localparam int WN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int BD_W   = $clog2(BAD_MAX + 1);
  localparam int BL_W   = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(RATIO - 1);
  localparam logic [WC_W-1:0]  WC_ONE   = WC_W'(1);
  localparam logic [GC_W-1:0]  GC_LAST  = GC_W'(LOCK_CNT - 1);
  localparam logic [GC_W-1:0]  GC_ONE   = GC_W'(1);
  localparam logic [WN_W-1:0]  WN_LAST  = WN_W'(WINDOW - 1);
  localparam logic [WN_W-1:0]  WN_ONE   = WN_W'(1);
  localparam logic [BD_W-1:0]  BD_LAST  = BD_W'(BAD_MAX - 1);
  localparam logic [BD_W-1:0]  BD_ONE   = BD_W'(1);
  localparam logic [BL_W-1:0]  BL_INIT  = BL_W'(SLIP_WAIT);
  localparam logic [BL_W-1:0]  BL_ONE   = BL_W'(1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(OUT_W - 1);
  localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

  state_t            state;
  logic [HIST_W-1:0] hist;
  logic [BUF_W-1:0]  nxt;
  logic [OUT_W-1:0]  blk;
  logic [WC_W-1:0]   word_cnt;
  logic [GC_W-1:0]   good_cnt;
  logic [WN_W-1:0]   win_cnt;
  logic [BD_W-1:0]   bad_cnt;
  logic [BL_W-1:0]   blank;
  logic              capture;
  logic              hdr_good;

  // Only the low HIST_W bits of the 2*OUT_W window are ever read back, so only those are stored.
  assign nxt      = {hist, data_in};
  assign blk      = nxt[bit_offset +: OUT_W];
  assign hdr_good = blk[OUT_W-1] ^ blk[OUT_W-2];
  assign capture  = (word_cnt == WC_LAST);

  function automatic logic [OFF_W-1:0] next_offset(input logic [OFF_W-1:0] off);
    return (off == OFF_LAST) ? '0 : off + OFF_ONE;
  endfunction

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      hist       <= '0;
      word_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      bit_offset <= '0;
      state      <= HUNT;
      good_cnt   <= '0;
      win_cnt    <= '0;
      bad_cnt    <= '0;
      blank      <= '0;
    end else begin
      hist       <= nxt[HIST_W-1:0];
      data_valid <= 1'b0;
      if (!capture) begin
        word_cnt <= word_cnt + WC_ONE;
      end else begin
        word_cnt   <= '0;
        data_out   <= blk;
        data_valid <= 1'b1;
        if (blank != '0) begin
          blank <= blank - BL_ONE;
        end else begin
          case (state)
            HUNT: begin
              if (hdr_good) begin
                if (LOCK_CNT == 1) begin
                  state    <= LOCK;
                  locked   <= 1'b1;
                  good_cnt <= '0;
                  win_cnt  <= '0;
                  bad_cnt  <= '0;
                end else begin
                  state    <= VERIFY;
                  good_cnt <= GC_ONE;
                end
              end else begin
                bit_offset <= next_offset(bit_offset);
                blank      <= BL_INIT;
              end
            end
            VERIFY: begin
              if (hdr_good) begin
                if (good_cnt == GC_LAST) begin
                  state    <= LOCK;
                  locked   <= 1'b1;
                  good_cnt <= '0;
                  win_cnt  <= '0;
                  bad_cnt  <= '0;
                end else begin
                  good_cnt <= good_cnt + GC_ONE;
                end
              end else begin
                state      <= HUNT;
                good_cnt   <= '0;
                bit_offset <= next_offset(bit_offset);
                blank      <= BL_INIT;
              end
            end
            LOCK: begin
              // Loss of lock wins over the window rollover on the same block.
              if (!hdr_good && (bad_cnt == BD_LAST)) begin
                state    <= HUNT;
                locked   <= 1'b0;
                good_cnt <= '0;
                win_cnt  <= '0;
                bad_cnt  <= '0;
              end else if (win_cnt == WN_LAST) begin
                win_cnt <= '0;
                bad_cnt <= '0;
              end else begin
                win_cnt <= win_cnt + WN_ONE;
                if (!hdr_good) begin
                  bad_cnt <= bad_cnt + BD_ONE;
                end
              end
            end
            default: begin
              state  <= HUNT;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gearbox_rx_sync.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for gearbox_rx_sync: default instance plus a 32x2 / LOCK_CNT=1 instance,
// each compared every cycle against a bit-queue model of the gearbox and lock rules.
module tb_gearbox_rx_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [19:0] din_a;
  logic [31:0] din_b;
  logic [79:0] dout_a;
  logic [63:0] dout_b;
  logic        val_a, val_b, lck_a, lck_b;
  logic [6:0]  off_a;
  logic [5:0]  off_b;

  gearbox_rx_sync dut_a (
    .user_clk(clk), .reset_n(rst_a), .data_in(din_a), .data_out(dout_a),
    .data_valid(val_a), .locked(lck_a), .bit_offset(off_a)
  );

  gearbox_rx_sync #(.IN_W(32), .RATIO(2), .LOCK_CNT(1)) dut_b (
    .user_clk(clk), .reset_n(rst_b), .data_in(din_b), .data_out(dout_b),
    .data_valid(val_b), .locked(lck_b), .bit_offset(off_b)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCK = 2;
  localparam int M_WINDOW = 1024, M_BADMAX = 16, M_SLIPW = 4;

  function automatic int p_inw(int id);   return (id == 0) ? 20 : 32; endfunction
  function automatic int p_ratio(int id); return (id == 0) ? 4 : 2;   endfunction
  function automatic int p_lock(int id);  return (id == 0) ? 64 : 1;  endfunction

  bit hq0[$];
  bit hq1[$];
  int m_wc[2], m_st[2], m_gc[2], m_win[2], m_bad[2], m_blank[2], m_off[2];
  logic [127:0] m_dout[2];
  bit m_val[2], m_lck[2];

  function automatic void push_bit(int id, bit b);
    if (id == 0) begin
      hq0.push_back(b);
      if (hq0.size() > 400) void'(hq0.pop_front());
    end else begin
      hq1.push_back(b);
      if (hq1.size() > 400) void'(hq1.pop_front());
    end
  endfunction

  // back = 0 is the most recently received bit
  function automatic bit get_bit(int id, int back);
    if (id == 0) return hq0[hq0.size() - 1 - back];
    return hq1[hq1.size() - 1 - back];
  endfunction

  function automatic void model_reset(int id);
    if (id == 0) hq0.delete(); else hq1.delete();
    for (int i = 0; i < 2 * p_inw(id) * p_ratio(id); i++) push_bit(id, 1'b0);
    m_wc[id] = 0; m_st[id] = M_HUNT; m_gc[id] = 0; m_win[id] = 0; m_bad[id] = 0;
    m_blank[id] = 0; m_off[id] = 0; m_dout[id] = '0; m_val[id] = 0; m_lck[id] = 0;
  endfunction

  function automatic void slip(int id);
    m_off[id] = (m_off[id] + 1) % (p_inw(id) * p_ratio(id));
    m_blank[id] = M_SLIPW;
  endfunction

  function automatic void judge(int id, bit good);
    case (m_st[id])
      M_HUNT: begin
        if (good) begin
          if (p_lock(id) == 1) begin m_st[id] = M_LOCK; m_win[id] = 0; m_bad[id] = 0; end
          else begin m_st[id] = M_VERIFY; m_gc[id] = 1; end
        end else slip(id);
      end
      M_VERIFY: begin
        if (good) begin
          m_gc[id]++;
          if (m_gc[id] == p_lock(id)) begin m_st[id] = M_LOCK; m_win[id] = 0; m_bad[id] = 0; end
        end else begin
          slip(id); m_st[id] = M_HUNT; m_gc[id] = 0;
        end
      end
      default: begin
        // window counted as blocks seen in it, 1..WINDOW
        m_win[id]++;
        if (!good) m_bad[id]++;
        if (m_bad[id] == M_BADMAX) begin
          m_st[id] = M_HUNT; m_gc[id] = 0; m_win[id] = 0; m_bad[id] = 0;
        end else if (m_win[id] == M_WINDOW) begin
          m_win[id] = 0; m_bad[id] = 0;
        end
      end
    endcase
  endfunction

  function automatic void model_step(int id, logic [31:0] w);
    int ow = p_inw(id) * p_ratio(id);
    logic [127:0] blk = '0;
    for (int j = p_inw(id) - 1; j >= 0; j--) push_bit(id, w[j]);
    m_val[id] = 0;
    if (m_wc[id] < p_ratio(id) - 1) begin
      m_wc[id]++;
    end else begin
      m_wc[id] = 0;
      for (int i = 0; i < ow; i++) blk[i] = get_bit(id, m_off[id] + i);
      m_dout[id] = blk;
      m_val[id] = 1;
      if (m_blank[id] > 0) m_blank[id]--;
      else judge(id, blk[ow-1] != blk[ow-2]);
      m_lck[id] = (m_st[id] == M_LOCK);
    end
  endfunction

  task automatic cmp_model(input int id, input logic [127:0] d, input bit v, input bit l, input int o);
    n_total++;
    if (d === m_dout[id] && v == m_val[id] && l == m_lck[id] && o == m_off[id]) n_pass++;
    else $display("FAIL model_%0d @%0t: dout=0x%0h/0x%0h valid=%0b/%0b locked=%0b/%0b off=%0d/%0d (got/expected)",
                  id, $time, d, m_dout[id], v, m_val[id], l, m_lck[id], o, m_off[id]);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_a) model_step(0, {12'b0, din_a});
    if (rst_b) model_step(1, din_b);
    #1;
    cmp_model(0, {48'b0, dout_a}, val_a, lck_a, int'(off_a));
    cmp_model(1, {64'b0, dout_b}, val_b, lck_b, int'(off_b));
  endtask

  task automatic reset_a(input int cycles);
    rst_a = 1'b0;
    model_reset(0);
    repeat (cycles) begin din_a = 20'($urandom); step(); end
    rst_a = 1'b1;
  endtask

  // ---------------- stream generator for instance A ----------------
  int mis_a;
  int t_a;
  bit bad_blk[4096];

  // Block header at pos 0/1 (01 good, 11 when flagged bad); pos 2..8 forced to 1 so
  // every misaligned offset below the true one sees an 11 header.
  function automatic bit sbit(int t);
    int pos = (t + mis_a) % 80;
    int blk = (t + mis_a) / 80;
    if (pos == 0) return bad_blk[blk];
    if (pos <= 8) return 1'b1;
    return 1'($urandom);
  endfunction

  function automatic logic [19:0] gen_a();
    logic [19:0] w;
    for (int j = 19; j >= 0; j--) begin w[j] = sbit(t_a); t_a++; end
    return w;
  endfunction

  task automatic start_stream(input int mis);
    mis_a = mis; t_a = 0;
    for (int i = 0; i < 4096; i++) bad_blk[i] = 1'b0;
  endtask

  typedef struct {
    logic [19:0] w0, w1, w2, w3;
    logic [79:0] dout;
    logic [6:0]  off;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cap, slips, last_slip, lock_cap, prev, first_v, second_v;
    int rise1, rise2, fall, fall_off, nfall, wrap, wrap_slips, lockb, lock_off;
    bit prev_l, saw_lock, good_mode;

    vecs[0] = '{20'h11111, 20'h22222, 20'h33333, 20'h44444, 80'h11111222223333344444, 7'd1};
    vecs[1] = '{20'h5A5A5, 20'h0F0F0, 20'hFFFFF, 20'h00001, 80'h5A5A50F0F0FFFFF00001, 7'd0};
    vecs[2] = '{20'h8000F, 20'h12345, 20'h6789A, 20'hBCDEF, 80'h8000F123456789ABCDEF, 7'd0};
    vecs[3] = '{20'hC0000, 20'h00000, 20'h00000, 20'h00003, 80'hC0000000000000000003, 7'd1};

    rst_a = 1'b0; rst_b = 1'b0; din_a = '0; din_b = '0;
    model_reset(0); model_reset(1);

    // reset with random input
    repeat (6) begin din_a = 20'($urandom); din_b = $urandom; step(); end
    chk("rst_dout", {48'b0, dout_a}, 128'd0);
    chk("rst_valid", {127'b0, val_a}, 128'd0);
    chk("rst_locked", {127'b0, lck_a}, 128'd0);
    chk("rst_offset", {121'b0, off_a}, 128'd0);

    // release: strobe on the 4th cycle, then every 4
    rst_a = 1'b1; first_v = -1; second_v = -1;
    for (int c = 1; c <= 9; c++) begin
      din_a = 20'($urandom); step();
      if (val_a) begin
        if (first_v < 0) first_v = c; else if (second_v < 0) second_v = c;
      end
    end
    chk("first_valid_cycle", 128'(first_v), 128'd4);
    chk("strobe_period", 128'(second_v - first_v), 128'd4);

    // ordering table at offset 0
    for (int v = 0; v < 4; v++) begin
      reset_a(2);
      din_a = vecs[v].w0; step();
      din_a = vecs[v].w1; step();
      din_a = vecs[v].w2; step();
      din_a = vecs[v].w3; step();
      chk($sformatf("vec%0d_dout", v), {48'b0, dout_a}, {48'b0, vecs[v].dout});
      chk($sformatf("vec%0d_valid", v), {127'b0, val_a}, 128'd1);
      chk($sformatf("vec%0d_offset", v), {121'b0, off_a}, {121'b0, vecs[v].off});
      din_a = 20'($urandom); step();
      chk($sformatf("vec%0d_valid_drop", v), {127'b0, val_a}, 128'd0);
    end

    // lock acquisition with a 7-bit misalignment
    reset_a(2); start_stream(7);
    cap = 0; slips = 0; last_slip = -1; lock_cap = -1; prev = 0;
    for (int c = 0; c < 2000 && lock_cap < 0; c++) begin
      din_a = gen_a(); step();
      if (val_a) begin
        if (int'(off_a) != prev) begin slips++; last_slip = cap; prev = int'(off_a); end
        if (lck_a) lock_cap = cap;
        cap++;
      end
    end
    chk("lock_slip_count", 128'(slips), 128'd7);
    chk("lock_offset", {121'b0, off_a}, 128'd7);
    chk("lock_blocks_after_slip", 128'(lock_cap - last_slip), 128'd68);

    // VERIFY failure at good_cnt = 30
    reset_a(2); start_stream(0); bad_blk[30] = 1'b1;
    cap = 0; saw_lock = 0;
    for (int c = 0; c < 400 && cap <= 30; c++) begin
      din_a = gen_a(); step();
      if (val_a) begin
        if (lck_a) saw_lock = 1;
        if (cap == 29) chk("verify_off_before", {121'b0, off_a}, 128'd0);
        if (cap == 30) begin
          chk("verify_bad_hdr", {126'b0, dout_a[79:78]}, 128'd3);
          chk("verify_off_after", {121'b0, off_a}, 128'd1);
        end
        cap++;
      end
    end
    chk("verify_blocks_seen", 128'(cap), 128'd31);
    chk("verify_never_locked", {127'b0, saw_lock}, 128'd0);

    // loss of lock: 15 bad (keep), 16 bad (lose), 15 across a window boundary (keep)
    reset_a(2); start_stream(0);
    for (int b = 70; b <= 84; b++) bad_blk[b] = 1'b1;
    for (int b = 1100; b <= 1115; b++) bad_blk[b] = 1'b1;
    for (int b = 2195; b <= 2209; b++) bad_blk[b] = 1'b1;
    cap = 0; rise1 = -1; rise2 = -1; fall = -1; fall_off = -1; nfall = 0; prev_l = 0;
    for (int c = 0; c < 10000 && cap <= 2230; c++) begin
      din_a = gen_a(); step();
      if (val_a) begin
        if (lck_a && !prev_l) begin
          if (rise1 < 0) rise1 = cap; else if (rise2 < 0) rise2 = cap;
        end
        if (!lck_a && prev_l) begin
          nfall++;
          if (fall < 0) begin fall = cap; fall_off = int'(off_a); end
        end
        prev_l = lck_a;
        cap++;
      end
    end
    chk("loss_blocks_seen", 128'(cap), 128'd2231);
    chk("loss_first_lock", 128'(rise1), 128'd63);
    chk("loss_fall_block", 128'(fall), 128'd1115);
    chk("loss_fall_offset", 128'(fall_off), 128'd0);
    chk("loss_relock", 128'(rise2), 128'd1179);
    chk("loss_fall_count", 128'(nfall), 128'd1);
    chk("loss_final_locked", {127'b0, lck_a}, 128'd1);

    // random traffic
    reset_a(3);
    repeat (400) begin din_a = 20'($urandom); step(); end

    // 32x2, LOCK_CNT=1: offset wrap 63 -> 0 then lock on first judged block
    rst_b = 1'b0; model_reset(1);
    repeat (3) begin din_a = 20'($urandom); din_b = $urandom; step(); end
    rst_b = 1'b1;
    cap = 0; slips = 0; prev = 0; wrap = -1; wrap_slips = -1; lockb = -1; lock_off = -1; good_mode = 0;
    for (int c = 0; c < 2000 && lockb < 0; c++) begin
      if (!good_mode) din_b = 32'hFFFF_FFFF;
      else if (c % 2 == 0) din_b = {2'b01, 30'($urandom)};
      else din_b = $urandom;
      din_a = 20'($urandom);
      step();
      if (val_b) begin
        if (int'(off_b) != prev) begin
          slips++;
          if (prev == 63 && off_b == 6'd0) begin wrap = cap; wrap_slips = slips; good_mode = 1; end
          prev = int'(off_b);
        end
        if (lck_b && lockb < 0) begin lockb = cap; lock_off = int'(off_b); end
        cap++;
      end
    end
    chk("sweep_wrap_slips", 128'(wrap_slips), 128'd64);
    chk("sweep_wrap_block", 128'(wrap), 128'd315);
    chk("sweep_lock_delay", 128'(lockb - wrap), 128'd5);
    chk("sweep_lock_offset", 128'(lock_off), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
